wfg_record_mem_top: RTL and testbench

- AXI-Stream sink that captures 32-bit waveform samples into the stimulus SRAM through its write port.
- It is the write-side counterpart of the stimulus-memory streamer: the streamer reads SRAM and drives AXI-Stream; this block accepts AXI-Stream and writes SRAM.
- Configured and monitored over the same Wishbone slave bus as the other wfg cores.
- Supports one-shot capture over an address window, or circular capture that wraps within the window.

---
 rtl/wfg_record_mem_top.sv | 149 ++++++++++++++
 tb/tb_wfg_record_mem_top.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_record_mem_top.sv
// wfg_record_mem_top: AXI-Stream sink that captures 32-bit samples into the stimulus SRAM write port.
// Define WFG_RECORD_IRQ_EN to add irq_o and the IRQ register at 0x14.
module wfg_record_mem_top #(
   parameter int BUSW = 32,
   parameter int AW = 10
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [BUSW-1:0] wbs_dat_i,
   input  logic [BUSW-1:0] wbs_adr_i,
   output logic            wbs_ack_o,
   output logic [BUSW-1:0] wbs_dat_o,
`ifdef WFG_RECORD_IRQ_EN
   output logic            irq_o,
`endif
   output logic            wfg_axis_tready_o,
   input  logic            wfg_axis_tvalid_i,
   input  logic [31:0]     wfg_axis_tdata_i,
   output logic            csb0,
   output logic            web0,
   output logic [3:0]      wmask0,
   output logic [AW-1:0]   addr0,
   output logic [31:0]     din0
);
   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
   state_t state;
   logic en, circ, circ_s, done, wrapped;
   logic [AW-1:0] start, stop, start_s, stop_s, ptr;
   logic [31:0] count, wmask;
   logic [BUSW-1:0] rdata;
   logic [2:0] idx;
   logic req, wr, clr, beat, last;
   logic unused;
`ifdef WFG_RECORD_IRQ_EN
   logic pending, mask;
`endif
   assign idx = wbs_adr_i[4:2];
   assign req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
   assign wr = req & wbs_we_i;
   assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign clr = wr && idx == 3'd0 && wbs_sel_i[0] && wbs_dat_i[2];
   assign beat = wfg_axis_tvalid_i & wfg_axis_tready_o;
   assign last = ptr == stop_s;
   assign unused = ^{wbs_adr_i, wbs_dat_i, wmask};
   always_comb begin
      rdata = '0;
      case (idx)
         3'd0: rdata[1:0] = {circ, en};
         3'd1: rdata[AW-1:0] = start;
         3'd2: rdata[AW-1:0] = stop;
         3'd3: begin
            rdata[2:0] = {wrapped, done, state == CAPTURE};
            rdata[AW+15:16] = ptr;
         end
         3'd4: rdata[31:0] = count;
`ifdef WFG_RECORD_IRQ_EN
         3'd5: rdata[1:0] = {mask, pending};
`endif
         default: rdata = '0;
      endcase
   end
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state <= IDLE;
         {en, circ, circ_s, done, wrapped} <= '0;
         {start, stop, start_s, stop_s, ptr} <= '0;
         count <= '0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         wfg_axis_tready_o <= 1'b0;
         csb0 <= 1'b1;
         web0 <= 1'b1;
         wmask0 <= '0;
         addr0 <= '0;
         din0 <= '0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
         if (wr && idx == 3'd0 && wbs_sel_i[0]) {circ, en} <= wbs_dat_i[1:0];
         if (wr && idx == 3'd1) start <= (start & ~wmask[AW-1:0]) | (wbs_dat_i[AW-1:0] & wmask[AW-1:0]);
         if (wr && idx == 3'd2) stop <= (stop & ~wmask[AW-1:0]) | (wbs_dat_i[AW-1:0] & wmask[AW-1:0]);
         // an accepted beat is always written one cycle later, even if the FSM leaves CAPTURE
         csb0 <= ~beat;
         web0 <= ~beat;
         wmask0 <= {4{beat}};
         if (beat) begin
            addr0 <= ptr;
            din0 <= wfg_axis_tdata_i;
         end
         if (clr) begin
            state <= IDLE;
            wfg_axis_tready_o <= 1'b0;
            {done, wrapped} <= '0;
            count <= '0;
            ptr <= '0;
         end else begin
            case (state)
               IDLE: if (en) begin
                  state <= CAPTURE;
                  wfg_axis_tready_o <= 1'b1;
                  ptr <= start;
                  start_s <= start;
                  stop_s <= stop;
                  circ_s <= circ;
                  count <= '0;
                  {done, wrapped} <= '0;
               end
               CAPTURE: begin
                  if (beat) begin
                     if (~&count) count <= count + 32'd1;
                     if (!last) ptr <= ptr + AW'(1);
                     else if (circ_s) begin
                        ptr <= start_s;
                        wrapped <= 1'b1;
                     end else done <= 1'b1;
                  end
                  if (!en) begin
                     state <= IDLE;
                     wfg_axis_tready_o <= 1'b0;
                  end else if (beat && last && !circ_s) begin
                     state <= DONE;
                     wfg_axis_tready_o <= 1'b0;
                  end
               end
               DONE: if (!en) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
`ifdef WFG_RECORD_IRQ_EN
   assign irq_o = pending & ~mask;
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         pending <= 1'b0;
         mask <= 1'b0;
      end else begin
         if (wr && idx == 3'd5 && wbs_sel_i[0]) mask <= wbs_dat_i[1];
         // set wins over a same-cycle clear
         if (state == CAPTURE && beat && last && !clr && (circ_s || en)) pending <= 1'b1;
         else if (wr && idx == 3'd5 && wbs_sel_i[0] && wbs_dat_i[0]) pending <= 1'b0;
      end
   end
`endif
endmodule

// File: tb/tb_wfg_record_mem_top.sv
// tb_wfg_record_mem_top: directed register vectors plus stream capture sequences for wfg_record_mem_top.
module tb_wfg_record_mem_top;
   typedef struct {
      logic we;
      logic [4:0] adr;
      logic [31:0] dat;
      logic [3:0] sel;
      logic [31:0] exp;
   } vec_t;
   logic clk = 0, rst_n = 0, stb = 0, cyc = 0, we = 0;
   logic [3:0] sel = 0;
   logic [31:0] wdat = 0, adr = 0, rdat;
   logic ack, tready, tvalid = 0;
   logic [31:0] tdata = 0;
   logic csb0, web0;
   logic [3:0] wmask0;
   logic [9:0] addr0;
   logic [31:0] din0;
`ifdef WFG_RECORD_IRQ_EN
   logic irq;
`endif
   int tests = 0, fails = 0, cyc_n = 0;
   logic mon = 0, acc_q = 0;
   logic [31:0] dat_q = 0;
   logic [9:0] qa[$];
   logic [31:0] qd[$];
   int qc[$];

   always #5 clk = ~clk;

   wfg_record_mem_top dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
`ifdef WFG_RECORD_IRQ_EN
      .irq_o(irq),
`endif
      .wfg_axis_tready_o(tready), .wfg_axis_tvalid_i(tvalid), .wfg_axis_tdata_i(tdata),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   // acceptance seen at a rising edge must produce exactly one SRAM write in the following cycle
   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      acc_q <= tvalid & tready & rst_n;
      dat_q <= tdata;
   end
   always @(negedge clk) if (mon && (acc_q || !csb0 || !web0)) begin
      chk("wr_latency", 32'(!csb0 && !web0), 32'(acc_q));
      if (!csb0 && !web0) begin
         chk("wr_data", din0, dat_q);
         chk("wr_mask", 32'(wmask0), 32'hF);
         qa.push_back(addr0);
         qd.push_back(din0);
         qc.push_back(cyc_n);
      end
   end

   task automatic wb_xfer(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
      int n;
      @(negedge clk);
      stb = 1; cyc = 1; we = w; adr = 32'(a); wdat = d; sel = s;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ack && n < 8);
      r = rdat;
      if (!ack) chk("wb_ack_timeout", 32'(ack), 1);
      stb = 0; cyc = 0; we = 0;
   endtask
   task automatic wb_w(input logic [4:0] a, input logic [31:0] d);
      logic [31:0] r;
      wb_xfer(1, a, d, 4'hF, r);
   endtask
   task automatic wb_chk(string name, input logic [4:0] a, input logic [31:0] e);
      logic [31:0] r;
      wb_xfer(0, a, 0, 4'hF, r);
      chk(name, r, e);
   endtask
   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!tready && n < 6) begin
         @(negedge clk); n++;
      end
      chk("tready_rise", 32'(tready), 1);
   endtask
   task automatic drive(input int n, input logic [31:0] base, input logic [31:0] pat, input int cycles, output int got);
      got = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (got > 0 && tvalid && tready) ;
         tvalid = pat[c % 32] && got < n;
         tdata = base + 32'(got);
         if (tvalid && tready) got++;
      end
      @(negedge clk);
      tvalid = 0;
      @(negedge clk);
   endtask
   task automatic qclear();
      qa.delete(); qd.delete(); qc.delete();
   endtask

   initial begin
      vec_t vt[21];
      int got;
      int ea[10];
      int off[4];
      vt[0]  = '{1'b0, 5'h00, 32'h0, 4'hF, 32'h0};
      vt[1]  = '{1'b0, 5'h04, 32'h0, 4'hF, 32'h0};
      vt[2]  = '{1'b0, 5'h08, 32'h0, 4'hF, 32'h0};
      vt[3]  = '{1'b0, 5'h0C, 32'h0, 4'hF, 32'h0};
      vt[4]  = '{1'b0, 5'h10, 32'h0, 4'hF, 32'h0};
      vt[5]  = '{1'b0, 5'h14, 32'h0, 4'hF, 32'h0};
      vt[6]  = '{1'b0, 5'h18, 32'h0, 4'hF, 32'h0};
      vt[7]  = '{1'b1, 5'h04, 32'h3AB, 4'hF, 32'h0};
      vt[8]  = '{1'b0, 5'h04, 32'h0, 4'hF, 32'h3AB};
      vt[9]  = '{1'b1, 5'h04, 32'hFFFF_F155, 4'h1, 32'h0};
      vt[10] = '{1'b0, 5'h04, 32'h0, 4'hF, 32'h355};
      vt[11] = '{1'b1, 5'h08, 32'h12FF, 4'h2, 32'h0};
      vt[12] = '{1'b0, 5'h08, 32'h0, 4'hF, 32'h200};
      vt[13] = '{1'b1, 5'h00, 32'h2, 4'hF, 32'h0};
      vt[14] = '{1'b0, 5'h00, 32'h0, 4'hF, 32'h2};
      vt[15] = '{1'b1, 5'h00, 32'h5, 4'hE, 32'h0};
      vt[16] = '{1'b0, 5'h00, 32'h0, 4'hF, 32'h2};
      vt[17] = '{1'b1, 5'h00, 32'h4, 4'hF, 32'h0};
      vt[18] = '{1'b0, 5'h00, 32'h0, 4'hF, 32'h0};
      vt[19] = '{1'b1, 5'h0C, 32'hFFFF, 4'hF, 32'h0};
      vt[20] = '{1'b0, 5'h0C, 32'h0, 4'hF, 32'h0};
      ea = '{32'h3FE, 32'h3FF, 32'h000, 32'h001, 32'h3FE, 32'h3FF, 32'h000, 32'h001, 32'h3FE, 32'h3FF};
      off = '{0, 2, 3, 5};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", 32'(tready), 0);
      chk("rst_csb0", 32'(csb0), 1);
      chk("rst_web0", 32'(web0), 1);
      chk("rst_wmask0", 32'(wmask0), 0);
      chk("rst_ack", 32'(ack), 0);
      rst_n = 1;
      mon = 1;

      for (int i = 0; i < 21; i++) begin
         logic [31:0] r;
         wb_xfer(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, r);
         if (!vt[i].we) chk($sformatf("reg_vec%0d", i), r, vt[i].exp);
      end

      // one-shot capture 0x010..0x013
      qclear();
      wb_w(5'h04, 32'h010); wb_w(5'h08, 32'h013); wb_w(5'h00, 32'h1);
      drive(6, 32'hA0, 32'hFFFF_FFFF, 10, got);
      chk("os_beats", 32'(got), 4);
      chk("os_tready", 32'(tready), 0);
      wb_chk("os_status", 5'h0C, 32'h0013_0002);
      wb_chk("os_count", 5'h10, 32'd4);
      chk("os_nwr", 32'(qa.size()), 4);
      if (qa.size() == 4) for (int i = 0; i < 4; i++) begin
         chk($sformatf("os_addr%0d", i), 32'(qa[i]), 32'h10 + 32'(i));
         chk($sformatf("os_data%0d", i), qd[i], 32'hA0 + 32'(i));
         chk($sformatf("os_cyc%0d", i), 32'(qc[i] - qc[0]), 32'(i));
      end
      wb_w(5'h00, 32'h0);

      // circular capture wrapping through 0x3FF
      qclear();
      wb_w(5'h04, 32'h3FE); wb_w(5'h08, 32'h001); wb_w(5'h00, 32'h3);
      drive(10, 32'hB0, 32'hFFFF_FFFF, 14, got);
      chk("circ_beats", 32'(got), 10);
      chk("circ_tready", 32'(tready), 1);
      wb_chk("circ_status", 5'h0C, 32'h0000_0005);
      wb_chk("circ_count", 5'h10, 32'd10);
      chk("circ_nwr", 32'(qa.size()), 10);
      if (qa.size() == 10) for (int i = 0; i < 10; i++)
         chk($sformatf("circ_addr%0d", i), 32'(qa[i]), 32'(ea[i]));
      wb_w(5'h00, 32'h0);

      // gapped source
      qclear();
      wb_w(5'h04, 32'h040); wb_w(5'h08, 32'h04F); wb_w(5'h00, 32'h1);
      wait_ready();
      drive(6, 32'hC0, 32'h2D, 6, got);
      chk("gap_beats", 32'(got), 4);
      wb_chk("gap_count", 5'h10, 32'd4);
      chk("gap_nwr", 32'(qa.size()), 4);
      if (qa.size() == 4) for (int i = 0; i < 4; i++) begin
         chk($sformatf("gap_addr%0d", i), 32'(qa[i]), 32'h40 + 32'(i));
         chk($sformatf("gap_cyc%0d", i), 32'(qc[i] - qc[0]), 32'(off[i]));
      end
      wb_w(5'h00, 32'h0);

      // en drops in the cycle a beat is accepted at 0x020, then clr
      qclear();
      wb_w(5'h04, 32'h020); wb_w(5'h08, 32'h030); wb_w(5'h00, 32'h1);
      wait_ready();
      wb_w(5'h00, 32'h0);
      @(negedge clk);
      tvalid = 1; tdata = 32'hD0;
      @(negedge clk);
      tvalid = 0;
      @(negedge clk);
      chk("endrop_tready", 32'(tready), 0);
      chk("endrop_nwr", 32'(qa.size()), 1);
      if (qa.size() == 1) begin
         chk("endrop_addr", 32'(qa[0]), 32'h20);
         chk("endrop_data", qd[0], 32'hD0);
      end
      wb_chk("endrop_status", 5'h0C, 32'h0021_0000);
      wb_chk("endrop_count", 5'h10, 32'd1);
      wb_w(5'h00, 32'h4);
      wb_chk("clr_status", 5'h0C, 32'h0);
      wb_chk("clr_count", 5'h10, 32'h0);

      // single-word window
      qclear();
      wb_w(5'h04, 32'h050); wb_w(5'h08, 32'h050); wb_w(5'h00, 32'h1);
      drive(3, 32'hE0, 32'hFFFF_FFFF, 5, got);
      chk("one_beats", 32'(got), 1);
      chk("one_nwr", 32'(qa.size()), 1);
      if (qa.size() == 1) chk("one_addr", 32'(qa[0]), 32'h50);
      wb_chk("one_status", 5'h0C, 32'h0050_0002);
`ifdef WFG_RECORD_IRQ_EN
      chk("irq_set", 32'(irq), 1);
      wb_chk("irq_reg_pend", 5'h14, 32'h1);
      wb_w(5'h14, 32'h2);
      chk("irq_masked", 32'(irq), 0);
      wb_chk("irq_reg_mask", 5'h14, 32'h3);
      wb_w(5'h14, 32'h1);
      wb_chk("irq_reg_clr", 5'h14, 32'h0);
      chk("irq_cleared", 32'(irq), 0);
`endif
      wb_w(5'h00, 32'h0);

      // reset during an accepting edge cancels the write
      qclear();
      wb_w(5'h04, 32'h060); wb_w(5'h08, 32'h06F); wb_w(5'h00, 32'h1);
      wait_ready();
      @(negedge clk);
      tvalid = 1; tdata = 32'hF0; rst_n = 0;
      @(negedge clk);
      chk("rstw_csb0", 32'(csb0), 1);
      chk("rstw_web0", 32'(web0), 1);
      chk("rstw_tready", 32'(tready), 0);
      tvalid = 0; rst_n = 1;
      @(negedge clk);
      chk("rstw_nwr", 32'(qa.size()), 0);
      wb_chk("rstw_ctrl", 5'h00, 32'h0);
      wb_chk("rstw_start", 5'h04, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
